// File: rtl/servo_pkg.sv
// Shared constants, types and angle-to-width conversion for the servo PWM bank.
// SERVO_ANGLE_CLAMP_EN: when defined, angles above 180 are clamped before conversion.
package servo_pkg;

  localparam int unsigned DEG_MAX    = 180;
  localparam int unsigned FRAME_CLKS = 1_000_000;
  localparam int unsigned MIN_CLKS   = 25_000;
  localparam int unsigned MAX_CLKS   = 125_000;
  localparam int unsigned WIDTH_W    = 20;

  typedef logic [WIDTH_W-1:0] width_t;
  typedef logic [7:0]         angle_t;

  typedef enum logic {StEmpty, StFull} buf_state_e;

  function automatic width_t angle_to_width(angle_t angle, width_t min_clks, width_t step);
    angle_t a;
    a = angle;
`ifdef SERVO_ANGLE_CLAMP_EN
    if (a > angle_t'(DEG_MAX)) a = angle_t'(DEG_MAX);
`endif
    return min_clks + step * width_t'(a);
  endfunction

endpackage

// File: rtl/servo_pwm_channel.sv
// One servo channel: pending width, active width and the registered PWM compare.
module servo_pwm_channel
  import servo_pkg::*;
#(
  parameter width_t MinClks = width_t'(MIN_CLKS),
  parameter width_t Step    = width_t'((MAX_CLKS - MIN_CLKS) / DEG_MAX)
) (
  input  logic   clk_i,
  input  logic   reset_i,
  input  logic   capture_i,
  input  logic   apply_i,
  input  angle_t angle_i,
  input  width_t fcnt_i,
  input  logic   en_i,
  output logic   pwm_o
);

  localparam width_t DefWidth = angle_to_width(angle_t'(90), MinClks, Step);

  width_t pending_q, pending_d;
  width_t active_q, active_d;
  logic   pwm_q, pwm_d;

  always_comb begin
    pending_d = pending_q;
    active_d  = active_q;
    if (capture_i) pending_d = angle_to_width(angle_i, MinClks, Step);
    if (apply_i)   active_d  = pending_q;
    pwm_d = en_i & (fcnt_i < active_q);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      pending_q <= DefWidth;
      active_q  <= DefWidth;
      pwm_q     <= 1'b0;
    end else begin
      pending_q <= pending_d;
      active_q  <= active_d;
      pwm_q     <= pwm_d;
    end
  end

  assign pwm_o = pwm_q;

endmodule

// File: rtl/servo_pwm_bank.sv
// Multi-channel servo PWM driver; new poses take effect only at frame boundaries.
// SERVO_ANGLE_CLAMP_EN (see servo_pkg) selects clamping of angles above 180.
module servo_pwm_bank
  import servo_pkg::*;
#(
  parameter int unsigned NCh       = 6,
  parameter int unsigned FrameClks = FRAME_CLKS,
  parameter int unsigned MinClks   = MIN_CLKS,
  parameter int unsigned MaxClks   = MAX_CLKS
) (
  input  logic           clk_i,
  input  logic           reset_i,
  input  logic           enable_i,
  input  logic [NCh*8-1:0] angle_i,
  input  logic           angle_valid_i,
  output logic           angle_ready_o,
  output logic [NCh-1:0] pwm_o,
  output logic           frame_start_o,
  output logic           active_en_o
);

  localparam width_t Step    = width_t'((MaxClks - MinClks) / DEG_MAX);
  localparam width_t LastCnt = width_t'(FrameClks - 1);

  width_t     fcnt_q, fcnt_d;
  buf_state_e state_q, state_d;
  logic       frame_start_q, frame_start_d;
  logic       active_en_q, active_en_d;
  logic       boundary, capture, apply;

  assign boundary = (fcnt_q == LastCnt);

  // Ready is forced low while reset is held so no pose is accepted then.
  assign angle_ready_o = (state_q == StEmpty) && !reset_i;

  always_comb begin
    fcnt_d        = boundary ? '0 : fcnt_q + width_t'(1);
    frame_start_d = (fcnt_q == '0);
    active_en_d   = boundary ? enable_i : active_en_q;
    state_d       = state_q;
    capture       = 1'b0;
    apply         = 1'b0;
    unique case (state_q)
      StEmpty: begin
        if (angle_valid_i && angle_ready_o) begin
          capture = 1'b1;
          state_d = StFull;
        end
      end
      StFull: begin
        if (boundary) begin
          apply   = 1'b1;
          state_d = StEmpty;
        end
      end
      default: state_d = StEmpty;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      fcnt_q        <= '0;
      state_q       <= StEmpty;
      frame_start_q <= 1'b0;
      active_en_q   <= 1'b0;
    end else begin
      fcnt_q        <= fcnt_d;
      state_q       <= state_d;
      frame_start_q <= frame_start_d;
      active_en_q   <= active_en_d;
    end
  end

  assign frame_start_o = frame_start_q;
  assign active_en_o   = active_en_q;

  for (genvar i = 0; i < NCh; i++) begin : g_ch
    servo_pwm_channel #(
      .MinClks (width_t'(MinClks)),
      .Step    (Step)
    ) u_ch (
      .clk_i     (clk_i),
      .reset_i   (reset_i),
      .capture_i (capture),
      .apply_i   (apply),
      .angle_i   (angle_i[8*i +: 8]),
      .fcnt_i    (fcnt_q),
      .en_i      (active_en_q),
      .pwm_o     (pwm_o[i])
    );
  end

endmodule

// File: doc/servo_pwm_bank.md
# servo_pwm_bank

Six-channel hobby-servo PWM driver that sits directly downstream of the per-joint angle slew stage. It accepts a full pose of joint angles through a valid/ready handshake and converts each angle (0–180°) to a pulse width in clock cycles. It applies new widths only at 20 ms frame boundaries, so a pulse is never cut short or stretched mid-frame, and drives one PWM pin per joint.

## Interface
- N_CH, 6, number of servo channels
- FRAME_CLKS, 1_000_000, frame period in clocks (20 ms at 50 MHz)
- MIN_CLKS, 25_000, pulse width at 0° (0.5 ms)
- MAX_CLKS, 125_000, nominal pulse width at 180° (2.5 ms)
- clk  in  1  system clock, 50 MHz
- reset  in  1  synchronous, active-high reset
- enable  in  1  output enable; sampled only at frame start
- angle  in  N_CH*8  packed angles; channel i is in bits [8i+7:8i], in degrees
- angle_valid  in  1  pose offered
- angle_ready  out  1  pending buffer free
- pwm  out  N_CH  servo pulse outputs, registered
- frame_start  out  1  one-cycle pulse on the first cycle of each frame
- active_en  out  1  enable value latched for the current frame

## Operation
- Arithmetic:
  - STEP = (MAX_CLKS − MIN_CLKS)/180, integer-truncated; with defaults STEP = 555.
  - width = MIN_CLKS + STEP·angle, computed unsigned in 20 bits.
  - Example: 90° → 74_950; 180° → 124_900.
- Frame counter fcnt:
  - Counts 0..FRAME_CLKS−1, then wraps to 0.
  - The boundary is the cycle where fcnt == FRAME_CLKS−1.
- Pending buffer, two states:
  - EMPTY: angle_ready = 1. When angle_valid & angle_ready, capture widths computed from `angle` and go to FULL.
  - FULL: angle_ready = 0. At the boundary, copy pending widths to active widths and go to EMPTY.
- Handshake on the boundary cycle while EMPTY: the pose is captured into pending and applied at the following boundary, not the current one.
- Several poses offered while FULL: stalled by angle_ready = 0; no pose is dropped or overwritten.
- Enable:
  - active_en ← enable at the boundary.
  - A mid-frame change of enable has no effect until the next frame.
- Outputs: pwm[i] ← active_en & (fcnt < active_width[i]). A width of 0 is impossible by construction.
- Reset values:
  - fcnt = 0, pwm = 0, frame_start = 0, active_en = 0.
  - Pending state = EMPTY; angle_ready = 0 during reset and 1 on the first cycle after reset deasserts.
  - All active widths = 90° width (74_950).
- Reset mid-frame aborts the frame immediately. Any pending pose is discarded.

## Timing
- pwm is registered, one cycle behind fcnt. The rising edge falls on the cycle after fcnt = 0, i.e. the same cycle as frame_start.
- High time is exactly active_width[i] cycles; period is exactly FRAME_CLKS cycles.
- frame_start is asserted in the cycle after fcnt wraps to 0.
- Capture-to-apply latency: a pose captured at fcnt = k first appears in the frame starting at the next boundary, within FRAME_CLKS − k cycles.
- angle_ready falls in the cycle after the handshake and rises in the cycle after the boundary transfer.

## Configuration
- SERVO_ANGLE_CLAMP_EN
  - Defined: angles > 180 are clamped to 180 before width calculation, so the pulse never exceeds MIN_CLKS + 180·STEP.
  - Undefined: the raw 8-bit angle is used. Angle 255 yields 166_525 clocks; this is legal only while below FRAME_CLKS.

## Structure
- Shared package servo_pkg holds:
  - Constants: DEG_MAX = 180, default FRAME_CLKS, MIN_CLKS, MAX_CLKS.
  - Width typedef: 20-bit unsigned.
  - Pure function angle_to_width (clamp under the macro).
- One sub-module, servo_pwm_channel: holds pending width, active width and the output compare register for one channel. It is instantiated N_CH times; the frame counter and handshake FSM remain in the parent.

## Test plan
- Reset release, no pose offered → all pwm high 74_950 cycles per 1_000_000 once enable = 1 has been latched at a boundary; angle_ready = 1.
- Pose {0,30,60,90,120,180} offered at fcnt = 500 → applied at next frame; high times 25_000 / 41_650 / 58_300 / 74_950 / 91_600 / 124_900.
- Second pose held valid while FULL → angle_ready = 0 until the boundary; second pose captured the cycle after the boundary and applied one frame later.
- Handshake exactly on the boundary cycle → pose not used in the immediate frame; applied in the following frame.
- enable dropped at fcnt = 30_000 → current frame pulses complete unchanged; the next frame has pwm all low and active_en = 0.
- Angle 200 → 124_900 with SERVO_ANGLE_CLAMP_EN; 136_000 without.
